// File: rtl/sys_seg_ctrl.sv
// sys_seg_ctrl: one-second centre-button hold detector, switch latch and
// 8-digit multiplexed hex display driver.
// Optional build macro SEG_DP_SEPARATOR_EN lights the decimal point on
// digits 6, 4 and 2 as field separators; without it the dp stays off.
module sys_seg_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int CLK400HZ = 250_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_c,
    input  logic [7:0] num,
    input  logic [1:0] speed,
    input  logic [1:0] num_of_bytes,
    input  logic [7:0] byte_count,
    output logic       one_sec_push,
    output logic [7:0] latched_num,
    output logic [7:0] latched_speed,
    output logic [7:0] latched_num_of_bytes,
    output logic [7:0] cathode,
    output logic [7:0] anode
);

    localparam int HW = $clog2(CLK_FREQ + 1);
    localparam int RW = $clog2(CLK400HZ + 1);
    localparam logic [HW-1:0] HOLD_HIT = HW'(CLK_FREQ - 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(CLK_FREQ);
    localparam logic [RW-1:0] REF_TOP  = RW'(CLK400HZ - 1);

    logic          btn_s1, btn_s2;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] ref_cnt;
    logic [2:0]    digit_idx;
    logic [3:0]    nibble;
    logic          dp_bit;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Two-flop synchronizer for the raw push-button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_c;
            btn_s2 <= btn_s1;
        end
    end

    // Hold counter: clears on release, parks one past the hit value so a
    // single press produces a single pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hold_cnt <= '0;
        else if (!btn_s2)
            hold_cnt <= '0;
        else if (hold_cnt != HOLD_SAT)
            hold_cnt <= hold_cnt + 1'b1;
    end

    assign one_sec_push = (hold_cnt == HOLD_HIT);

    // Capture and decode the switches on the hold pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latched_num          <= '0;
            latched_speed        <= '0;
            latched_num_of_bytes <= '0;
        end else if (one_sec_push) begin
            latched_num <= num;
            case (speed)
                2'd0:    latched_speed <= 8'h04;
                2'd1:    latched_speed <= 8'h08;
                2'd2:    latched_speed <= 8'h10;
                default: latched_speed <= 8'h20;
            endcase
            case (num_of_bytes)
                2'd0:    latched_num_of_bytes <= 8'h10;
                2'd1:    latched_num_of_bytes <= 8'h20;
                2'd2:    latched_num_of_bytes <= 8'h40;
                default: latched_num_of_bytes <= 8'h80;
            endcase
        end
    end

    // Refresh prescaler and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_cnt   <= '0;
            digit_idx <= '0;
        end else if (ref_cnt == REF_TOP) begin
            ref_cnt   <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Select the nibble and decimal point for the current digit
    always_comb begin
        nibble = 4'h0;
        dp_bit = 1'b1;
        case (digit_idx)
            3'd7: nibble = latched_num[7:4];
            3'd6: nibble = latched_num[3:0];
            3'd5: nibble = latched_speed[7:4];
            3'd4: nibble = latched_speed[3:0];
            3'd3: nibble = latched_num_of_bytes[7:4];
            3'd2: nibble = latched_num_of_bytes[3:0];
            3'd1: nibble = byte_count[7:4];
            default: nibble = byte_count[3:0];
        endcase
`ifdef SEG_DP_SEPARATOR_EN
        if (digit_idx == 3'd6 || digit_idx == 3'd4 || digit_idx == 3'd2)
            dp_bit = 1'b0;
`else
        dp_bit = 1'b1;
`endif
    end

    // Register anode and cathode together so they switch on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode   <= '1;
            cathode <= '1;
        end else begin
            anode   <= ~(8'd1 << digit_idx);
            cathode <= {dp_bit, seg7(nibble)};
        end
    end

endmodule

// File: tb/tb_sys_seg_ctrl.sv
// tb_sys_seg_ctrl: directed checks of hold detection, latching, digit scan,
// live byte_count display and reset behaviour.
module tb_sys_seg_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_c = 1'b0;
    logic [7:0] num = 8'h00;
    logic [1:0] speed = 2'd0;
    logic [1:0] num_of_bytes = 2'd0;
    logic [7:0] byte_count = 8'h00;
    logic       one_sec_push;
    logic [7:0] latched_num, latched_speed, latched_num_of_bytes;
    logic [7:0] cathode, anode;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned pulses = 0;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    sys_seg_ctrl #(.CLK_FREQ(1000), .CLK400HZ(100)) dut (
        .clk                 (clk),
        .reset               (reset),
        .btn_c               (btn_c),
        .num                 (num),
        .speed               (speed),
        .num_of_bytes        (num_of_bytes),
        .byte_count          (byte_count),
        .one_sec_push        (one_sec_push),
        .latched_num         (latched_num),
        .latched_speed       (latched_speed),
        .latched_num_of_bytes(latched_num_of_bytes),
        .cathode             (cathode),
        .anode               (anode)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (one_sec_push) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Wait (bounded) for the scan to newly enter digit idx; sampled on negedge
    task automatic wait_digit(input int idx);
        logic [7:0] tgt;
        int         n;
        logic       found;
        tgt   = ~(8'd1 << idx);
        n     = 0;
        found = 1'b0;
        while (anode == tgt && n < 2000) begin @(negedge clk); n++; end
        while (n < 2000) begin
            @(negedge clk); n++;
            if (anode == tgt) begin found = 1'b1; break; end
        end
        check($sformatf("wait_digit%0d", idx), {31'd0, found}, 32'd1);
    endtask

    function automatic logic [7:0] exp_cath(input int idx, input logic [7:0] bc);
        case (idx)
            7: exp_cath = 8'h88;   // A
            6: exp_cath = 8'h83;   // b
            5: exp_cath = 8'hF9;   // 1
            4: exp_cath = 8'hC0;   // 0
            3: exp_cath = 8'hA4;   // 2
            2: exp_cath = 8'hC0;   // 0
            1: exp_cath = glyph[bc[7:4]];
            default: exp_cath = glyph[bc[3:0]];
        endcase
    endfunction

    initial begin
        int          p0;
        int          n;
        logic [7:0]  prev;
        logic [7:0]  vals [$];

        // Reset state
        cycles(3);
        #1;
        check("rst_push", {31'd0, one_sec_push}, 32'd0);
        check("rst_lnum", {24'd0, latched_num}, 32'h00);
        check("rst_lspd", {24'd0, latched_speed}, 32'h00);
        check("rst_lnob", {24'd0, latched_num_of_bytes}, 32'h00);
        check("rst_anode", {24'd0, anode}, 32'hFF);
        check("rst_cath", {24'd0, cathode}, 32'hFF);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rel_anode", {24'd0, anode}, 32'hFE);
        check("rel_cath", {24'd0, cathode}, 32'hC0);

        // One-second hold latches the switches
        num = 8'hAB; speed = 2'd2; num_of_bytes = 2'd1;
        @(negedge clk);
        btn_c = 1'b1;
        cycles(1005);
        btn_c = 1'b0;
        cycles(5);
        check("hold_pulses", pulses, 1);
        check("hold_lnum", {24'd0, latched_num}, 32'hAB);
        check("hold_lspd", {24'd0, latched_speed}, 32'h10);
        check("hold_lnob", {24'd0, latched_num_of_bytes}, 32'h20);

        // Two short holds: no pulse, switch changes ignored
        num = 8'h12; speed = 2'd3; num_of_bytes = 2'd3;
        btn_c = 1'b1; cycles(900);
        btn_c = 1'b0; cycles(10);
        btn_c = 1'b1; cycles(900);
        btn_c = 1'b0; cycles(10);
        check("short_pulses", pulses, 1);
        check("short_lnum", {24'd0, latched_num}, 32'hAB);
        check("short_lspd", {24'd0, latched_speed}, 32'h10);
        check("short_lnob", {24'd0, latched_num_of_bytes}, 32'h20);

        // Long hold: exactly one pulse; other decode codes checked
        num = 8'hAB; speed = 2'd0; num_of_bytes = 2'd3;
        p0 = pulses;
        btn_c = 1'b1; cycles(3000);
        btn_c = 1'b0; cycles(5);
        check("long_pulses", pulses - p0, 1);
        check("long_lspd", {24'd0, latched_speed}, 32'h04);
        check("long_lnob", {24'd0, latched_num_of_bytes}, 32'h80);

        // Restore AB/10/20 for the display checks
        speed = 2'd2; num_of_bytes = 2'd1;
        btn_c = 1'b1; cycles(1010);
        btn_c = 1'b0; cycles(5);
        check("relatch_lspd", {24'd0, latched_speed}, 32'h10);

        // Scan order, dwell and glyphs
        byte_count = 8'h00;
        wait_digit(0);
        for (int k = 0; k <= 8; k++) begin
            check($sformatf("scan_anode%0d", k), {24'd0, anode}, {24'd0, ~(8'd1 << (k % 8))});
            check($sformatf("scan_cath%0d", k), {24'd0, cathode}, {24'd0, exp_cath(k % 8, byte_count)});
            if (k < 8) begin
                prev = anode;
                n = 0;
                do begin @(negedge clk); n++; end while (anode == prev && n < 500);
                check($sformatf("scan_dwell%0d", k), n, 100);
            end
        end

        // Live byte_count, stride through the range and wrap to zero
        for (int v = 0; v < 256; v += 17) vals.push_back(8'(v));
        vals.push_back(8'h5C);
        vals.push_back(8'hFF);
        vals.push_back(8'h00);
        foreach (vals[i]) begin
            byte_count = vals[i];
            wait_digit(1);
            check($sformatf("bc_hi_%02h", vals[i]), {24'd0, cathode}, {24'd0, glyph[vals[i][7:4]]});
            wait_digit(0);
            check($sformatf("bc_lo_%02h", vals[i]), {24'd0, cathode}, {24'd0, glyph[vals[i][3:0]]});
        end
        wait_digit(7);
        check("bc_d7", {24'd0, cathode}, 32'h88);
        wait_digit(3);
        check("bc_d3", {24'd0, cathode}, 32'hA4);

        // Reset mid-hold and mid-scan
        p0 = pulses;
        btn_c = 1'b1;
        cycles(500);
        #3 reset = 1'b1;
        #1;
        check("mid_push", {31'd0, one_sec_push}, 32'd0);
        check("mid_lnum", {24'd0, latched_num}, 32'h00);
        check("mid_lspd", {24'd0, latched_speed}, 32'h00);
        check("mid_lnob", {24'd0, latched_num_of_bytes}, 32'h00);
        check("mid_anode", {24'd0, anode}, 32'hFF);
        check("mid_cath", {24'd0, cathode}, 32'hFF);
        cycles(3);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rel_anode", {24'd0, anode}, 32'hFE);
        cycles(900);
        check("mid_abort_pulses", pulses - p0, 0);
        check("mid_abort_lnum", {24'd0, latched_num}, 32'h00);
        cycles(200);
        btn_c = 1'b0;
        cycles(5);
        check("mid_new_pulses", pulses - p0, 1);
        check("mid_new_lnum", {24'd0, latched_num}, 32'hAB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sys_seg_ctrl.md
SYS_SEG_CTRL -- requirements
Module: sys_seg_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, clock cycles that make up a one-second button hold.
REQ-002 Parameter CLK400HZ, default 250_000, clock cycles each display digit is held before advancing.
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 btn_c  in  1  centre push-button, raw and asynchronous.
REQ-006 num  in  8  data byte from switches.
REQ-007 speed  in  2  speed-select index from switches.
REQ-008 num_of_bytes  in  2  byte-count-select index from switches.
REQ-009 byte_count  in  8  live progress counter from the transfer FSM.
REQ-010 one_sec_push  out  1  one-cycle pulse when the one-second hold is detected.
REQ-011 latched_num  out  8  captured num.
REQ-012 latched_speed  out  8  decoded speed code.
REQ-013 latched_num_of_bytes  out  8  decoded byte-total code.
REQ-014 cathode  out  8  active-low segments; bit0=a ... bit6=g, bit7=dp.
REQ-015 anode  out  8  active-low digit enables; bit i selects digit i.

Function
REQ-016 btn_c SHALL pass through a 2-flop synchronizer before use.
REQ-017 A hold counter SHALL increment each cycle the synchronized button is 1 and SHALL clear to 0 on any cycle it is 0.
REQ-018 When the counter reaches CLK_FREQ-1, one_sec_push SHALL be 1 for exactly one cycle.
REQ-019 The counter SHALL then saturate, so a press yields only one pulse until the button is released.
REQ-020 On the pulse edge, the latched registers SHALL capture the current switches, visible the next cycle.
REQ-021 latched_num SHALL equal num.
REQ-022 latched_speed SHALL decode 0->0x04, 1->0x08, 2->0x10, 3->0x20.
REQ-023 latched_num_of_bytes SHALL decode 0->0x10, 1->0x20, 2->0x40, 3->0x80.
REQ-024 Latched values SHALL hold until the next pulse or reset; switch changes without a pulse have no effect.
REQ-025 A refresh counter SHALL wrap at CLK400HZ-1 and advance a 3-bit digit index 0..7, wrapping 7->0.
REQ-026 Digit map: digits 7,6 show the latched_num high/low nibble.
REQ-027 Digit map: digits 5,4 show latched_speed; digits 3,2 show latched_num_of_bytes; digits 1,0 show byte_count.
REQ-028 byte_count SHALL be displayed live, not latched; 0xFF->0x00 rollover SHALL display normally.
REQ-029 Hex glyphs, dp off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-030 anode SHALL have exactly one 0 bit, at the current index; anode and cathode SHALL be registered and change together.

Reset
REQ-031 While reset is 1: synchronizer, hold counter, refresh counter and digit index = 0.
REQ-032 While reset is 1: one_sec_push = 0, all latched outputs = 0x00, anode = 0xFF, cathode = 0xFF.
REQ-033 On the first edge after release, digit 0 SHALL be driven (anode = 0xFE).
REQ-034 Reset during a press SHALL abort it with no pulse; a new full hold SHALL be required after release.

Configuration
REQ-035 Macro SEG_DP_SEPARATOR_EN: when defined, cathode[7] SHALL be 0 on digits 6, 4 and 2 as field separators.
REQ-036 Without SEG_DP_SEPARATOR_EN, cathode[7] SHALL always be 1.

Verification
REQ-037 CLK_FREQ=1000: num=0xAB, speed=2, num_of_bytes=1, btn_c held 1005 cycles -> one pulse; latched AB/10/20.
REQ-038 btn_c held 900 cycles, released, held 900 cycles -> no pulse; latched outputs unchanged.
REQ-039 btn_c held 3000 cycles -> exactly one pulse.
REQ-040 CLK400HZ=100 after REQ-037 -> anode steps FE, FD, ... 7F, FE every 100 cycles; digit 7 cathode 0x88, digit 6 0x83.
REQ-041 byte_count swept 0x00..0xFF and wrapped -> digits 1,0 track each value (e.g. 0x5C -> 0x92, 0xC6); other digits unchanged.
REQ-042 Reset asserted mid-hold and mid-scan -> outputs at REQ-032 values at once; anode = 0xFE on the first edge after release.
